imm_gen_pipe: RTL and testbench

- Registered immediate/offset generator for the multicycle MIPS datapath; successor to the combinational offset extender.
- Decodes opcode into extension mode; produces a DATA_W-wide extended immediate plus a branch/jump target.
- Sits between instruction register and ALU/PC-select muxes. Valid/ready on both sides, 2-entry skid buffer, so a stalled consumer never drops an instruction.

---
 rtl/imm_gen_pipe_pkg.sv | 47 ++++
 rtl/imm_gen_pipe_core.sv | 55 +++++
 rtl/imm_gen_pipe.sv | 135 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants, extension modes and result-kind encodings
// for the registered immediate/target generator.
package imm_gen_pipe_pkg;

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    localparam logic [1:0] KIND_NONE   = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        MODE_SEXT,
        MODE_ZEXT,
        MODE_LUI,
        MODE_BRANCH,
        MODE_JUMP
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } pipe_state_e;

    // Anything not listed (ADDI, loads/stores, R-type, ...) sign-extends.
    function automatic imm_mode_e decode_mode(input logic [5:0] opcode);
        imm_mode_e mode;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI:          mode = MODE_ZEXT;
            OP_LUI:                            mode = MODE_LUI;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:  mode = MODE_BRANCH;
            OP_J, OP_JAL:                      mode = MODE_JUMP;
            default:                           mode = MODE_SEXT;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_core.sv
// Combinational opcode decode, immediate extension and branch/jump target
// calculation; feeds the output and skid registers of imm_gen_pipe.
module imm_gen_core
    import imm_gen_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26
) (
    input  logic [5:0]        opcode_i,
    input  logic [JIDX_W-1:0] jidx_i,
    input  logic [DATA_W-1:0] pc4_i,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] target_o,
    output logic [1:0]        kind_o
);

    imm_mode_e         mode;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_lui;
    logic [DATA_W-1:0] jaddr;
    logic [DATA_W-1:0] jmask;

    assign mode     = decode_mode(opcode_i);
    assign imm      = jidx_i[IMM_W-1:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign imm_lui  = DATA_W'({imm, {IMM_W{1'b0}}});
    // Jump keeps the PC region bits above the word-aligned instr_index.
    assign jaddr    = DATA_W'({jidx_i, 2'b00});
    assign jmask    = DATA_W'({(JIDX_W+2){1'b1}});

    always_comb begin
        imm_o    = imm_sext;
        target_o = '0;
        kind_o   = KIND_NONE;
        case (mode)
            MODE_ZEXT: imm_o = imm_zext;
            MODE_LUI:  imm_o = imm_lui;
            MODE_BRANCH: begin
                target_o = pc4_i + (imm_sext << 2);
                kind_o   = KIND_BRANCH;
            end
            MODE_JUMP: begin
                imm_o    = jaddr;
                target_o = (pc4_i & ~jmask) | jaddr;
                kind_o   = KIND_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate/target generator with valid/ready on both sides and
// a one-entry skid so a stalled consumer never loses an accepted beat.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [JIDX_W-1:0] in_jidx,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_target,
    output logic [1:0]        out_kind,
    output logic [TAG_W-1:0]  out_tag
);

    pipe_state_e       state_q, state_d;
    logic              in_ready_q;
    logic              accept;
    logic              load_out, load_skid, out_from_skid;

    logic [DATA_W-1:0] core_imm, core_target;
    logic [1:0]        core_kind;

    logic [DATA_W-1:0] out_imm_q, out_target_q, skid_imm_q, skid_target_q;
    logic [1:0]        out_kind_q, skid_kind_q;
    logic [TAG_W-1:0]  out_tag_q, skid_tag_q;

    imm_gen_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .JIDX_W (JIDX_W)
    ) u_core (
        .opcode_i (in_opcode),
        .jidx_i   (in_jidx),
        .pc4_i    (in_pc4),
        .imm_o    (core_imm),
        .target_o (core_target),
        .kind_o   (core_kind)
    );

    assign accept = in_valid & in_ready_q;

    // ONE with accept and drain replaces the output in place: no bubble.
    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_out = 1'b1;
                    state_d  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && out_ready) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    out_from_skid = 1'b1;
                    state_d       = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm_q     <= '0;
            out_target_q  <= '0;
            out_kind_q    <= KIND_NONE;
            out_tag_q     <= '0;
            skid_imm_q    <= '0;
            skid_target_q <= '0;
            skid_kind_q   <= KIND_NONE;
            skid_tag_q    <= '0;
        end else begin
            if (load_out) begin
                out_imm_q    <= core_imm;
                out_target_q <= core_target;
                out_kind_q   <= core_kind;
                out_tag_q    <= in_tag;
            end else if (out_from_skid) begin
                out_imm_q    <= skid_imm_q;
                out_target_q <= skid_target_q;
                out_kind_q   <= skid_kind_q;
                out_tag_q    <= skid_tag_q;
            end
            if (load_skid) begin
                skid_imm_q    <= core_imm;
                skid_target_q <= core_target;
                skid_kind_q   <= core_kind;
                skid_tag_q    <= in_tag;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_imm    = out_imm_q;
    assign out_target = out_target_q;
    assign out_kind   = out_kind_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed vectors plus a random valid/ready run against a golden decode
// model and an in-order scoreboard.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [25:0] in_jidx;
    logic [31:0] in_pc4;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic [1:0]  out_kind;
    logic [3:0]  out_tag;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] tgt;
        logic [1:0]  kind;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    imm_gen_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_jidx    (in_jidx),
        .in_pc4     (in_pc4),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_target (out_target),
        .out_kind   (out_kind),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t golden(input logic [5:0] op, input logic [25:0] jidx,
                                    input logic [31:0] pc4, input logic [3:0] tag);
        exp_t r;
        int   simm;
        simm   = int'($signed(jidx[15:0]));
        r.imm  = 32'(simm);
        r.tgt  = 32'h0;
        r.kind = 2'd0;
        r.tag  = tag;
        case (op)
            6'h0C, 6'h0D, 6'h0E: r.imm = 32'(jidx[15:0]);
            6'h0F:               r.imm = 32'(jidx[15:0]) * 32'h10000;
            6'h04, 6'h05, 6'h06, 6'h07: begin
                r.tgt  = pc4 + 32'(simm * 4);
                r.kind = 2'd1;
            end
            6'h02, 6'h03: begin
                r.imm  = 32'(jidx) * 32'd4;
                r.tgt  = (pc4 & 32'hF000_0000) + 32'(jidx) * 32'd4;
                r.kind = 2'd2;
            end
            default: ;
        endcase
        return r;
    endfunction

    // Handshakes are observed mid-cycle; inputs change only at posedge+2.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready)
                sb_q.push_back(golden(in_opcode, in_jidx, in_pc4, in_tag));
            if (out_valid && out_ready) begin
                check_eq("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("sb_imm",  64'(out_imm),    64'(e.imm));
                    check_eq("sb_tgt",  64'(out_target), 64'(e.tgt));
                    check_eq("sb_kind", 64'(out_kind),   64'(e.kind));
                    check_eq("sb_tag",  64'(out_tag),    64'(e.tag));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [5:0] op, input logic [25:0] jidx,
                         input logic [31:0] pc4, input logic [3:0] tag);
        in_valid  = 1'b1;
        in_opcode = op;
        in_jidx   = jidx;
        in_pc4    = pc4;
        in_tag    = tag;
    endtask

    task automatic apply(input string name, input logic [5:0] op, input logic [25:0] jidx,
                         input logic [31:0] pc4, input logic [3:0] tag,
                         input logic [31:0] e_imm, input logic [31:0] e_tgt, input logic [1:0] e_kind);
        out_ready = 1'b1;
        drive(op, jidx, pc4, tag);
        check_eq({name, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_eq({name, "_valid"}, 64'(out_valid),  64'd1);
        check_eq({name, "_imm"},   64'(out_imm),    64'(e_imm));
        check_eq({name, "_tgt"},   64'(out_target), 64'(e_tgt));
        check_eq({name, "_kind"},  64'(out_kind),   64'(e_kind));
        check_eq({name, "_tag"},   64'(out_tag),    64'(tag));
        tick();
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_out_valid"}, 64'(out_valid),  64'd0);
        check_eq({name, "_in_ready"},  64'(in_ready),   64'd1);
        check_eq({name, "_imm"},       64'(out_imm),    64'd0);
        check_eq({name, "_tgt"},       64'(out_target), 64'd0);
        check_eq({name, "_kind"},      64'(out_kind),   64'd0);
        check_eq({name, "_tag"},       64'(out_tag),    64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time=%0t, required finish before 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] op_tab [13];
        int  sent;
        int  cyc;
        int  waitc;
        bit  acc_last;
        bit  did_rst;

        op_tab = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0C,
                   6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h23, 6'h00};

        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(6'b001000, {10'h2A5, 16'hFFFC}, 32'h0000_1000, 4'h7);
        #1 rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("rst_first_valid", 64'(out_valid), 64'd1);
        check_eq("rst_first_imm",   64'(out_imm),   64'hFFFF_FFFC);
        check_eq("rst_first_tag",   64'(out_tag),   64'h7);
        tick();

        apply("addi", 6'b001000, {10'h2A5, 16'hFFFC}, 32'h0000_0100, 4'h1, 32'hFFFF_FFFC, 32'h0, 2'b00);
        apply("ori",  6'b001101, {10'h3FF, 16'h8001}, 32'h0000_0100, 4'h2, 32'h0000_8001, 32'h0, 2'b00);
        apply("xori", 6'b001110, {10'h000, 16'hFFFF}, 32'h0000_0100, 4'h3, 32'h0000_FFFF, 32'h0, 2'b00);
        apply("lui",  6'b001111, {10'h155, 16'h1234}, 32'h0000_0100, 4'h4, 32'h1234_0000, 32'h0, 2'b00);
        apply("sw",   6'b101011, {10'h000, 16'h8000}, 32'h0000_0100, 4'h5, 32'hFFFF_8000, 32'h0, 2'b00);
        apply("bgtz", 6'b000111, {10'h000, 16'hFFFF}, 32'h0040_0010, 4'h6, 32'hFFFF_FFFF, 32'h0040_000C, 2'b01);
        apply("beq",  6'b000100, {10'h000, 16'h0001}, 32'hFFFF_FFFC, 4'h8, 32'h0000_0001, 32'h0000_0000, 2'b01);
        apply("j",    6'b000010, 26'h0100000,         32'hA000_0004, 4'h9, 32'h0040_0000, 32'hA040_0000, 2'b10);
        apply("jal",  6'b000011, 26'h3FF_FFFF,        32'h1234_5678, 4'hA, 32'h0FFF_FFFC, 32'h1FFF_FFFC, 2'b10);

        // Backpressure: third beat must wait at the input while the skid is full.
        out_ready = 1'b0;
        drive(6'b001000, 26'h0000011, 32'h0, 4'h1);
        tick();
        drive(6'b001000, 26'h0000022, 32'h0, 4'h2);
        check_eq("bp_ready_after1", 64'(in_ready), 64'd1);
        tick();
        drive(6'b001000, 26'h0000033, 32'h0, 4'h3);
        check_eq("bp_ready_after2", 64'(in_ready), 64'd0);
        check_eq("bp_tag_hold_a",   64'(out_tag),  64'h1);
        tick();
        check_eq("bp_ready_full",   64'(in_ready), 64'd0);
        check_eq("bp_tag_hold_b",   64'(out_tag),  64'h1);
        check_eq("bp_imm_hold",     64'(out_imm),  64'h11);
        out_ready = 1'b1;
        tick();
        check_eq("bp_tag_2",        64'(out_tag),  64'h2);
        check_eq("bp_ready_again",  64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_tag_3",        64'(out_tag),  64'h3);
        check_eq("bp_imm_3",        64'(out_imm),  64'h33);
        tick();
        check_eq("bp_drained",      64'(out_valid), 64'd0);

        sent     = 0;
        cyc      = 0;
        acc_last = 1'b0;
        did_rst  = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (sent >= 500 && !did_rst) begin
                did_rst  = 1'b1;
                in_valid = 1'b0;
                rst_n    = 1'b0;
                #1;
                check_reset_outputs("midrst");
                tick();
                tick();
                rst_n    = 1'b1;
                acc_last = 1'b0;
            end
            if (!in_valid || acc_last) begin
                if ($urandom_range(0, 9) < 7)
                    drive(op_tab[$urandom_range(0, 12)], 26'($urandom), $urandom, 4'($urandom));
                else
                    in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) < 6);
            acc_last  = in_valid && in_ready;
            if (acc_last) sent++;
            tick();
            cyc++;
        end
        check_eq("rand_all_sent", 64'(sent), 64'd1000);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitc     = 0;
        while ((sb_q.size() != 0 || out_valid) && waitc < 50) begin
            tick();
            waitc++;
        end
        check_eq("drain_sb_empty", 64'(sb_q.size()), 64'd0);
        check_eq("drain_out_idle", 64'(out_valid),    64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
